// File: rtl/zet_post_responder.sv
// zet_post_responder
//   Wishbone classic slave terminating the BIOS POST-code ports 0x0080/0x0081
//   on the Zet switch's slave 1 interface. CPU writes to 0x80 are queued in a
//   small FIFO and drained through a valid/ready byte stream; port 0x81 reads
//   back FIFO status plus a sticky overflow flag. Ack latency is set by WAIT.
//
//   Optional feature macro: ZET_POST_IRQ_EN
//     defined   -> irq_o = registered (overflow | count >= THRESH)
//     undefined -> irq_o tied low, THRESH unused
module zet_post_responder #(
  parameter int DEPTH  = 16,  // FIFO entries, power of 2, 2..64
  parameter int WAIT   = 1,   // wait states before ack, 0..15
  parameter int THRESH = 8    // irq level threshold, 1..DEPTH
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic [20:1] wb_adr_i,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic [7:0]  post_dat_o,
  output logic        post_vld_o,
  input  logic        post_rdy_i,
  output logic        irq_o
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [14:0] PORT_WORD = 15'h0040;  // word address of 0x80/0x81

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t      state_q,     state_d;
  logic [3:0]  wait_cnt_q,  wait_cnt_d;
  logic [AW:0] wr_ptr_q,    wr_ptr_d;
  logic [AW:0] rd_ptr_q,    rd_ptr_d;
  logic [7:0]  last_code_q, last_code_d;
  logic        overflow_q,  overflow_d;
  logic        post_vld_q,  post_vld_d;
  logic [7:0]  post_dat_q,  post_dat_d;

  logic [7:0]  fifo_mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Decode and FIFO status (all from pre-edge state)
  // ---------------------------------------------------------------------------
  logic        req;
  logic        hit;
  logic        commit;
  logic        wr_lo;
  logic        wr_hi;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        drop;
  logic        pop;
  logic [AW:0] count_q;
  logic [AW:0] count_d;
  logic [6:0]  count_ext;
  logic [7:0]  status_byte;

  assign req    = wb_cyc_i & wb_stb_i;
  assign hit    = wb_adr_i[20] & (wb_adr_i[15:1] == PORT_WORD);
  // Side effects land on the edge that closes the single ACK cycle.
  assign commit = (state_q == ST_ACK) & req;
  assign wr_lo  = commit & hit & wb_we_i & wb_sel_i[0];
  assign wr_hi  = commit & hit & wb_we_i & wb_sel_i[1];

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_q    = wr_ptr_q - rd_ptr_q;
  assign count_ext  = 7'(count_q);

  // A push against a full FIFO is lost even if a pop frees a slot that edge.
  assign push = wr_lo & ~fifo_full;
  assign drop = wr_lo &  fifo_full;
  // post_vld_q always mirrors "not empty", so pops never underflow.
  assign pop  = post_vld_q & post_rdy_i;

  assign status_byte = {count_ext[4:0], overflow_q, fifo_full, fifo_empty};

  // ---------------------------------------------------------------------------
  // Responder FSM: next state and wait counter
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and synthesis never has to infer a latch.
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (WAIT == 0) begin
            state_d = ST_ACK;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = 4'(WAIT);
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_d = ST_IDLE;  // master gave up: no ack, no side effect
        end else if (wait_cnt_q == 4'd1) begin
          state_d = ST_ACK;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;  // forced idle cycle between back-to-back acks
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register-side datapath: pointers, last code, overflow, stream head
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, pop};
    count_d     = wr_ptr_d - rd_ptr_d;

    last_code_d = last_code_q;
    if (wr_lo) begin
      last_code_d = wb_dat_i[7:0];  // recorded even when the push is dropped
    end

    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;            // a new overflow wins over a clear
    end else if (wr_hi && wb_dat_i[10]) begin
      overflow_d = 1'b0;
    end

    post_vld_d = (count_d != '0);

    // The head register is reloaded every edge from the post-edge read pointer.
    // When this edge's push becomes the head, memory still holds the old byte,
    // so forward the write data instead.
    if (count_d == '0) begin
      post_dat_d = 8'h00;
    end else if (push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
      post_dat_d = wb_dat_i[7:0];
    end else begin
      post_dat_d = fifo_mem[rd_ptr_d[AW-1:0]];
    end
  end

  // ---------------------------------------------------------------------------
  // Control and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= 4'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      last_code_q <= 8'h00;
      overflow_q  <= 1'b0;
      post_vld_q  <= 1'b0;
      post_dat_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      last_code_q <= last_code_d;
      overflow_q  <= overflow_d;
      post_vld_q  <= post_vld_d;
      post_dat_q  <= post_dat_d;
    end
  end

  // FIFO storage write port
  always_ff @(posedge wb_clk_i) begin
    // NOTE: the storage array has no reset; resetting the pointers already
    // empties the FIFO, and an unreset array maps onto plain RAM cells.
    if (push) begin
      fifo_mem[wr_ptr_q[AW-1:0]] <= wb_dat_i[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Wishbone read data and ack: driven only during ACK, zero elsewhere
  // ---------------------------------------------------------------------------
  always_comb begin
    wb_dat_o = 16'h0000;
    if ((state_q == ST_ACK) && hit && !wb_we_i) begin
      if (wb_sel_i[0]) wb_dat_o[7:0]  = last_code_q;
      if (wb_sel_i[1]) wb_dat_o[15:8] = status_byte;
    end
  end

  assign wb_ack_o   = (state_q == ST_ACK);
  assign post_vld_o = post_vld_q;
  assign post_dat_o = post_dat_q;

  // ---------------------------------------------------------------------------
  // Optional level interrupt
  // ---------------------------------------------------------------------------
`ifdef ZET_POST_IRQ_EN
  logic irq_q, irq_d;

  // Interrupt follows the registered FIFO state, one cycle behind it
  always_comb begin
    irq_d = overflow_q | (count_ext >= 7'(THRESH));
  end

  // Interrupt register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_o = irq_q;

  logic unused_ok;
  assign unused_ok = ^{wb_adr_i[19:16], wb_dat_i[15:11], wb_dat_i[9:8], count_ext[6:5]};
`else
  assign irq_o = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{wb_adr_i[19:16], wb_dat_i[15:11], wb_dat_i[9:8], count_ext[6:5],
                       7'(THRESH)};
`endif

endmodule

// File: tb/tb_zet_post_responder.sv
// tb_zet_post_responder
//   Directed bench for zet_post_responder. Read expectations and streamed
//   bytes are queued when the stimulus is issued and compared when the DUT
//   acks or hands a byte over the post stream.
module tb_zet_post_responder;

  localparam int DEPTH_P    = 16;
  localparam int WAIT_P     = 1;
  localparam int THRESH_P   = 8;
  localparam int ACK_BUDGET = 40;

  logic        clk;
  logic        wb_rst_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic [20:1] wb_adr_i;
  logic [1:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_ack_o;
  logic [7:0]  post_dat_o;
  logic        post_vld_o;
  logic        post_rdy_i;
  logic        irq_o;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  int         m_count = 0;  // expected FIFO occupancy
  logic [7:0] stream_q [$]; // bytes expected on the post stream, in order
  logic [15:0] rd_exp [$];  // expected read data, one per outstanding read

  zet_post_responder #(
    .DEPTH (DEPTH_P),
    .WAIT  (WAIT_P),
    .THRESH(THRESH_P)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (wb_rst_i),
    .wb_dat_i  (wb_dat_i),
    .wb_dat_o  (wb_dat_o),
    .wb_adr_i  (wb_adr_i),
    .wb_sel_i  (wb_sel_i),
    .wb_we_i   (wb_we_i),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_ack_o  (wb_ack_o),
    .post_dat_o(post_dat_o),
    .post_vld_o(post_vld_o),
    .post_rdy_i(post_rdy_i),
    .irq_o     (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [20:1] io_adr(input logic [15:0] port);
    return {1'b1, 4'h0, port[15:1]};
  endfunction

  // Stream consumer side: compare each byte handed over against the scoreboard
  always @(negedge clk) begin
    if (!wb_rst_i && post_vld_o && post_rdy_i) begin
      check("stream_expected_avail", 16'(stream_q.size() != 0), 16'd1);
      if (stream_q.size() != 0) begin
        check("stream_byte", {8'h00, post_dat_o}, {8'h00, stream_q.pop_front()});
      end
      m_count--;
    end
  end

  // One Wishbone classic cycle; optionally pops the stream on the commit edge.
  task automatic xfer(input logic [20:1] adr, input logic we, input logic [1:0] sel,
                      input logic [15:0] dat, input bit pop_here, input string tag);
    bit          got;
    int          lat;
    logic [15:0] exp;
    got = 1'b0;
    lat = 0;
    wb_adr_i = adr;
    wb_we_i  = we;
    wb_sel_i = sel;
    wb_dat_i = dat;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    for (int n = 1; n <= ACK_BUDGET; n++) begin
      tick();
      if (wb_ack_o) begin
        got = 1'b1;
        lat = n;
        break;
      end
    end
    check({tag, "_ack_seen"}, 16'(got), 16'd1);
    if (!we) exp = rd_exp.pop_front();
    if (got) begin
      check({tag, "_ack_latency"}, 16'(lat), 16'(WAIT_P + 1));
      if (!we) begin
        check({tag, "_rdata"}, wb_dat_o, exp);
      end else if (adr[20] && (adr[15:1] == 15'h0040) && sel[0]) begin
        // Full is judged on pre-edge occupancy
        if (m_count < DEPTH_P) begin
          stream_q.push_back(dat[7:0]);
          m_count++;
        end
      end
      if (pop_here) post_rdy_i = 1'b1;
      tick();
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_sel_i = 2'b00;
    if (pop_here) post_rdy_i = 1'b0;
    check({tag, "_ack_single"}, 16'(wb_ack_o), 16'd0);
  endtask

  task automatic io_write(input logic [15:0] port, input logic [1:0] sel,
                          input logic [15:0] dat, input bit pop_here, input string tag);
    xfer(io_adr(port), 1'b1, sel, dat, pop_here, tag);
  endtask

  task automatic io_read(input logic [15:0] port, input logic [1:0] sel,
                         input logic [15:0] exp, input string tag);
    rd_exp.push_back(exp);
    xfer(io_adr(port), 1'b0, sel, 16'h0000, 1'b0, tag);
  endtask

  task automatic drain(input int cycles);
    post_rdy_i = 1'b1;
    repeat (cycles) tick();
    post_rdy_i = 1'b0;
  endtask

  // Watch for a spurious ack over a number of cycles
  task automatic expect_no_ack(input int cycles, input string tag);
    bit saw;
    saw = 1'b0;
    repeat (cycles) begin
      tick();
      if (wb_ack_o) saw = 1'b1;
    end
    check(tag, 16'(saw), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_rst_i   = 1'b1;
    wb_dat_i   = 16'h0000;
    wb_adr_i   = '0;
    wb_sel_i   = 2'b00;
    wb_we_i    = 1'b0;
    wb_cyc_i   = 1'b0;
    wb_stb_i   = 1'b0;
    post_rdy_i = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_ack",      16'(wb_ack_o),   16'd0);
    check("rst_dat_o",    wb_dat_o,        16'h0000);
    check("rst_post_vld", 16'(post_vld_o), 16'd0);
    check("rst_post_dat", 16'(post_dat_o), 16'h0000);
    check("rst_irq",      16'(irq_o),      16'd0);
    wb_rst_i = 1'b0;
    tick();

    // First POST code: no fall-through, head valid the cycle after ack
    io_write(16'h0080, 2'b01, 16'h0055, 1'b0, "wr55");
    check("wr55_post_vld", 16'(post_vld_o), 16'd1);
    check("wr55_post_dat", 16'(post_dat_o), 16'h0055);
    io_read(16'h0080, 2'b01, 16'h0055, "rd80");
    io_read(16'h0080, 2'b11, 16'h0855, "rd_both");     // count 1, not empty

    // Fill to 16, then overflow with 0xAA
    for (int i = 1; i < DEPTH_P; i++) begin
      io_write(16'h0080, 2'b01, 16'(8'h10 + i), 1'b0, "fill");
    end
    io_write(16'h0080, 2'b01, 16'h00AA, 1'b0, "wr_over");
    io_read(16'h0081, 2'b10, 16'h8600, "stat_full");   // count 16, ovf, full
    io_read(16'h0080, 2'b01, 16'h00AA, "last_aa");
    tick();
    tick();
`ifdef ZET_POST_IRQ_EN
    check("irq_full", 16'(irq_o), 16'd1);
`else
    check("irq_off_full", 16'(irq_o), 16'd0);
`endif

    // Clear overflow through port 0x81
    io_write(16'h0081, 2'b10, 16'h0400, 1'b0, "clr_ovf");
    io_read(16'h0081, 2'b10, 16'h8200, "stat_clr");
    tick();
    tick();
`ifdef ZET_POST_IRQ_EN
    check("irq_level_16", 16'(irq_o), 16'd1);
`endif

    // Drain 9 -> 7 entries (irq level drops below threshold)
    drain(9);
    tick();
    tick();
`ifdef ZET_POST_IRQ_EN
    check("irq_below_thresh", 16'(irq_o), 16'd0);
`else
    check("irq_off_7", 16'(irq_o), 16'd0);
`endif
    io_read(16'h0081, 2'b10, 16'h3800, "stat_7");

    // Down to 5, then push and pop on the same edge
    drain(2);
    io_read(16'h0081, 2'b10, 16'h2800, "stat_5");
    io_write(16'h0080, 2'b01, 16'h0077, 1'b1, "push_pop");
    io_read(16'h0081, 2'b10, 16'h2800, "stat_5_after");

    // Drain everything; ordering is checked by the stream consumer
    drain(8);
    check("drained_queue", 16'(stream_q.size()), 16'd0);
    check("drained_vld",   16'(post_vld_o),      16'd0);
    io_read(16'h0081, 2'b11, 16'h0177, "stat_empty");

    // Strobe dropped during WAIT: no ack, nothing pushed
    wb_adr_i = io_adr(16'h0080);
    wb_we_i  = 1'b1;
    wb_sel_i = 2'b01;
    wb_dat_i = 16'h0033;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    tick();
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
    expect_no_ack(4, "abort_no_ack");
    io_read(16'h0081, 2'b11, 16'h0177, "stat_abort");

    // Non-matching I/O port and memory-space hit on the same word: acked, inert
    io_read(16'h0060, 2'b11, 16'h0000, "rd_0060");
    xfer({1'b0, 4'h0, 15'h0040}, 1'b1, 2'b01, 16'h0099, 1'b0, "mem_wr");
    io_read(16'h0080, 2'b01, 16'h0077, "last_after_mem");

    // Reset during the WAIT of a push
    io_write(16'h0080, 2'b01, 16'h0012, 1'b0, "wr12");
    wb_adr_i = io_adr(16'h0080);
    wb_we_i  = 1'b1;
    wb_sel_i = 2'b01;
    wb_dat_i = 16'h0034;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    tick();
    wb_rst_i = 1'b1;
    #1;
    check("mrst_ack",      16'(wb_ack_o),   16'd0);
    check("mrst_dat_o",    wb_dat_o,        16'h0000);
    check("mrst_post_vld", 16'(post_vld_o), 16'd0);
    check("mrst_post_dat", 16'(post_dat_o), 16'h0000);
    check("mrst_irq",      16'(irq_o),      16'd0);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    stream_q.delete();
    m_count = 0;
    tick();
    wb_rst_i = 1'b0;
    expect_no_ack(4, "mrst_no_ack");
    io_read(16'h0081, 2'b11, 16'h0100, "stat_after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
